// File: rtl/letc_core_icache.sv
// letc_core_icache
//   Direct-mapped, read-only instruction cache sitting between the fetch stage
//   and the core's shared AXI request FSM (LIMP interface). Tag, valid and data
//   arrays are flop based. A miss fills the whole line, word 0 first, using
//   sequential single-word LIMP reads. i_flush (fence.i) invalidates all lines.
//
// Ports
//   i_clk, i_rst_n       clock, asynchronous active-low reset
//   i_req_valid/o_req_ready/i_req_addr   fetch request (34-bit paddr, [1:0] ignored)
//   o_rsp_valid/o_rsp_data               one-cycle response strobe + instruction word
//   i_flush                              invalidate every line
//   o_limp_*/i_limp_*                    single-word read requests to the AXI FSM
module letc_core_icache #(
  parameter int NUM_LINES      = 16,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [33:0] i_req_addr,
  output logic        o_rsp_valid,
  output logic [31:0] o_rsp_data,
  input  logic        i_flush,
  output logic        o_limp_valid,
  input  logic        i_limp_ready,
  output logic        o_limp_wen_nren,
  output logic [1:0]  o_limp_size,
  output logic [33:0] o_limp_addr,
  output logic [31:0] o_limp_wdata,
  input  logic [31:0] i_limp_rdata
);

  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int OFF_W = $clog2(WORDS_PER_LINE);
  localparam int TAG_W = 34 - 2 - OFF_W - IDX_W;

  localparam logic [1:0] SIZE_WORD = 2'b10;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COMPARE = 2'd1;
  localparam logic [1:0] ST_FILL    = 2'd2;

  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(WORDS_PER_LINE - 1);

  logic [1:0]       r_state;
  logic [33:2]      r_req_addr;
  logic [OFF_W-1:0] r_beat;
  logic             r_fill_abort;
  logic [NUM_LINES-1:0] r_valid;
  logic [TAG_W-1:0] r_tag  [NUM_LINES];
  logic [31:0]      r_data [NUM_LINES][WORDS_PER_LINE];

  logic [TAG_W-1:0] w_req_tag;
  logic [IDX_W-1:0] w_req_idx;
  logic [OFF_W-1:0] w_req_off;
  logic             w_hit;
  logic             w_accept;
  logic             w_beat_done;
  logic             w_last_beat;
  logic             w_unused_addr_bits;

  assign w_req_tag = r_req_addr[33 -: TAG_W];
  assign w_req_idx = r_req_addr[2+OFF_W +: IDX_W];
  assign w_req_off = r_req_addr[2 +: OFF_W];

  // Byte offset of the fetch address is meaningless for word fetches.
  assign w_unused_addr_bits = ^i_req_addr[1:0];

  assign w_hit = (r_state == ST_COMPARE) && r_valid[w_req_idx] &&
                 (r_tag[w_req_idx] == w_req_tag);

  // A flush blocks acceptance so the next lookup cannot hit a line it is
  // about to invalidate.
  assign o_req_ready = !i_flush && ((r_state == ST_IDLE) || w_hit);
  assign w_accept    = i_req_valid && o_req_ready;

  assign w_beat_done = (r_state == ST_FILL) && i_limp_ready;
  assign w_last_beat = (r_beat == LAST_BEAT);

  assign o_rsp_valid = w_hit;
  assign o_rsp_data  = r_data[w_req_idx][w_req_off];

  assign o_limp_valid    = (r_state == ST_FILL);
  assign o_limp_addr     = (r_state == ST_FILL) ? {w_req_tag, w_req_idx, r_beat, 2'b00} : '0;
  assign o_limp_wen_nren = 1'b0;
  assign o_limp_size     = SIZE_WORD;
  assign o_limp_wdata    = '0;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= ST_IDLE;
      r_req_addr   <= '0;
      r_beat       <= '0;
      r_fill_abort <= 1'b0;
      r_valid      <= '0;
    end else begin
      if (w_accept) r_req_addr <= i_req_addr[33:2];

      case (r_state)
        ST_IDLE: begin
          if (w_accept) r_state <= ST_COMPARE;
        end
        ST_COMPARE: begin
          if (w_hit) begin
            if (!w_accept) r_state <= ST_IDLE;
          end else begin
            r_state      <= ST_FILL;
            r_beat       <= '0;
            r_fill_abort <= 1'b0;
            // A half-filled line must never hit.
            r_valid[w_req_idx] <= 1'b0;
          end
        end
        ST_FILL: begin
          // The AXI read cannot be cancelled, so a flush only marks the
          // fill as stale; the re-lookup in COMPARE then refills the line.
          if (i_flush) r_fill_abort <= 1'b1;
          if (i_limp_ready) begin
            r_beat <= r_beat + 1'b1;
            if (w_last_beat) begin
              r_state            <= ST_COMPARE;
              r_valid[w_req_idx] <= !r_fill_abort && !i_flush;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase

      // Flush overrides any per-line valid update made this cycle.
      if (i_flush) r_valid <= '0;
    end
  end

  // Tag/data arrays carry no reset; the valid bits guard them.
  always_ff @(posedge i_clk) begin
    if (w_beat_done) begin
      r_data[w_req_idx][r_beat] <= i_limp_rdata;
      if (w_last_beat) r_tag[w_req_idx] <= w_req_tag;
    end
  end

endmodule

// File: tb/tb_letc_core_icache.sv
module tb_letc_core_icache;

  localparam int NL     = 16;
  localparam int WPL    = 4;
  localparam int LINE_B = WPL * 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [33:0] req_addr = '0;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        flush = 1'b0;
  logic        limp_valid;
  logic        limp_ready = 1'b0;
  logic        limp_wen_nren;
  logic [1:0]  limp_size;
  logic [33:0] limp_addr;
  logic [31:0] limp_wdata;
  logic [31:0] limp_rdata = '0;

  always #5 clk = ~clk;

  letc_core_icache #(.NUM_LINES(NL), .WORDS_PER_LINE(WPL)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_addr(req_addr),
    .o_rsp_valid(rsp_valid), .o_rsp_data(rsp_data),
    .i_flush(flush),
    .o_limp_valid(limp_valid), .i_limp_ready(limp_ready),
    .o_limp_wen_nren(limp_wen_nren), .o_limp_size(limp_size),
    .o_limp_addr(limp_addr), .o_limp_wdata(limp_wdata),
    .i_limp_rdata(limp_rdata)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Backing memory: content depends on address and a salt that the bench
  // changes to tell an old fill apart from a new one.
  int unsigned salt = 0;
  function automatic logic [31:0] memval(input logic [33:0] a);
    return a[31:0] ^ (salt * 32'h9E37_79B9);
  endfunction

  // Reference model: which line base address each index holds, and its words.
  bit          m_valid [NL];
  logic [33:0] m_base  [NL];
  logic [31:0] m_data  [NL][WPL];

  function automatic logic [33:0] base_of(input logic [33:0] a);
    return a - (a % 34'(LINE_B));
  endfunction
  function automatic int idx_of(input logic [33:0] a);
    return int'((a / 34'(LINE_B)) % 34'(NL));
  endfunction
  function automatic int off_of(input logic [33:0] a);
    return int'((a % 34'(LINE_B)) / 34'd4);
  endfunction
  function automatic bit model_hit(input logic [33:0] a);
    return m_valid[idx_of(a)] && (m_base[idx_of(a)] == base_of(a));
  endfunction
  task automatic model_flush();
    for (int i = 0; i < NL; i++) m_valid[i] = 1'b0;
  endtask

  // LIMP responder: random or fixed wait states per beat, logs beat addresses,
  // and checks that a stalled request holds steady.
  int max_wait   = 0;
  int fixed_wait = -1;
  logic [33:0] beats[$];

  initial begin
    int waited = 0;
    int target = 0;
    bit start = 1'b1;
    logic [33:0] prev = '0;
    forever begin
      @(negedge clk);
      limp_ready = 1'b0;
      if (!rst_n || !limp_valid) begin
        start = 1'b1;
        waited = 0;
      end else begin
        if (start) begin
          target = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(max_wait, 0));
          start  = 1'b0;
          waited = 0;
        end else if (waited > 0) begin
          check("stall_addr", limp_addr, prev);
          check("stall_ready", req_ready, 1'b0);
        end
        if (waited < target) begin
          waited++;
          prev = limp_addr;
        end else begin
          limp_ready = 1'b1;
          limp_rdata = memval(limp_addr);
          beats.push_back(limp_addr);
          start = 1'b1;
        end
      end
    end
  end

  task automatic do_fetch(input logic [33:0] a, input int exp_beats,
                          input bit chk_lat, input int exp_lat);
    int n;
    int lat;
    bit seen;
    logic [31:0] exp_d;
    logic [33:0] base;
    int idx;
    base = base_of(a);
    idx  = idx_of(a);
    beats.delete();
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = a;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("accept", n < 50, 1'b1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    seen = 1'b0;
    lat  = 0;
    while (!seen && lat < 500) begin
      @(negedge clk);
      lat++;
      seen = rsp_valid;
    end
    check("rsp_seen", seen, 1'b1);
    if (chk_lat) check("latency", lat, exp_lat);
    exp_d = (exp_beats > 0) ? memval(a - (a % 34'd4)) : m_data[idx][off_of(a)];
    check("rsp_data", rsp_data, exp_d);
    @(negedge clk);
    check("rsp_pulse", rsp_valid, 1'b0);
    check("beat_count", beats.size(), exp_beats);
    for (int i = 0; i < beats.size() && i < exp_beats; i++)
      check("beat_addr", beats[i], base + 34'((i % WPL) * 4));
    m_valid[idx] = 1'b1;
    m_base[idx]  = base;
    if (exp_beats > 0)
      for (int w = 0; w < WPL; w++) m_data[idx][w] = memval(base + 34'(w * 4));
  endtask

  task automatic fetch_auto(input logic [33:0] a);
    bit h;
    h = model_hit(a);
    do_fetch(a, h ? 0 : WPL, (max_wait == 0) && (fixed_wait < 0), h ? 1 : 2 + WPL);
  endtask

  initial begin
    logic [33:0] pool [3];
    logic [33:0] a;
    int n;
    pool[0] = 34'h0_0000_1000;
    pool[1] = 34'h0_0000_5000;
    pool[2] = 34'h3_FFFF_F000;
    model_flush();

    // Reset values
    repeat (3) @(negedge clk);
    #1;
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_limp_valid", limp_valid, 1'b0);
    check("rst_limp_addr", limp_addr, 34'h0);
    check("rst_req_ready", req_ready, 1'b1);
    check("tie_wen", limp_wen_nren, 1'b0);
    check("tie_size", limp_size, 2'b10);
    check("tie_wdata", limp_wdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Cold miss, zero-wait: data equals address with salt 0
    do_fetch(34'h1008, WPL, 1'b1, 6);
    check("cold_data_literal", m_data[0][2], 32'h0000_1008);

    // Back-to-back hits on the freshly filled line
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = 34'h1000;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check("b2b_rsp_valid", rsp_valid, 1'b1);
      check("b2b_data", rsp_data, 32'h1000 + 32'((k - 1) * 4));
      check("b2b_no_limp", limp_valid, 1'b0);
      if (k < 4) req_addr = 34'h1000 + 34'(k * 4);
      else req_valid = 1'b0;
    end
    @(negedge clk);
    check("b2b_end", rsp_valid, 1'b0);

    // Conflict eviction on index 0
    fetch_auto(34'h1100);
    fetch_auto(34'h1000);

    // Flush during a hit: response still delivered, new request refused
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = 34'h1004;
    @(negedge clk);
    flush = 1'b1;
    req_addr = 34'h1008;
    #1;
    check("flush_hit_rsp", rsp_valid, 1'b1);
    check("flush_hit_data", rsp_data, m_data[0][1]);
    check("flush_hit_ready", req_ready, 1'b0);
    @(negedge clk);
    flush = 1'b0;
    req_valid = 1'b0;
    model_flush();
    check("flush_hit_noacc", rsp_valid, 1'b0);
    fetch_auto(34'h1008);

    // Flush in IDLE beats a simultaneous request
    @(negedge clk);
    flush = 1'b1;
    #1 check("flush_idle_ready", req_ready, 1'b0);
    @(negedge clk);
    flush = 1'b0;
    model_flush();

    // Flush mid-fill (beat 2): line refetched, data from the second fill
    fetch_auto(34'h1000);
    fixed_wait = 2;
    fork
      do_fetch(34'h2004, 2 * WPL, 1'b0, 0);
      begin
        n = 0;
        while (beats.size() < 2 && n < 200) begin
          @(negedge clk);
          n++;
        end
        @(negedge clk);
        flush = 1'b1;
        salt++;
        model_flush();
        @(negedge clk);
        flush = 1'b0;
      end
    join
    fixed_wait = -1;
    fetch_auto(34'h1000);

    // Limp stall: five wait cycles per beat
    fixed_wait = 5;
    fetch_auto(34'h040C);
    fixed_wait = -1;

    // Reset in the middle of a fill
    fetch_auto(34'h3008);
    fixed_wait = 3;
    beats.delete();
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = 34'h0_0000_6000;
    @(posedge clk);
    #1 req_valid = 1'b0;
    n = 0;
    while (beats.size() < 1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("rstfill_beat0", beats.size(), 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rstfill_limp_valid", limp_valid, 1'b0);
    check("rstfill_rsp_valid", rsp_valid, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    model_flush();
    fixed_wait = -1;
    fetch_auto(34'h3008);
    fetch_auto(34'h0_0000_6000);

    // Randomized traffic over conflicting tags, all indices and offsets
    for (int i = 0; i < 60; i++) begin
      max_wait = (i % 2 == 1) ? 2 : 0;
      if ($urandom_range(7, 0) == 0) begin
        @(negedge clk);
        flush = 1'b1;
        #1 check("rnd_flush_ready", req_ready, 1'b0);
        @(negedge clk);
        flush = 1'b0;
        model_flush();
      end
      a = pool[$urandom_range(2, 0)] + 34'($urandom_range(NL - 1, 0) * LINE_B)
          + 34'($urandom_range(WPL - 1, 0) * 4) + 34'($urandom_range(3, 0));
      fetch_auto(a);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
